// File: rtl/frontend_pkg.sv
// Shared front-end helpers: popcount, power-of-two sizing and fetch_queue
// assertion messages.
package frontend_pkg;

    localparam int FQ_MAX_LANES = 64;

    localparam string FQ_MSG_OVERPOP = "fetch_queue: read_num_i exceeds occupancy, pop clamped";

    function automatic int unsigned popcount(input logic [FQ_MAX_LANES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < FQ_MAX_LANES; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned pow2_ceil(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if (r < n) r = r * 2;
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_queue_compact.sv
// Packs the set lanes of a fetch bundle to the front and maps packed slot j
// onto bank (wptr+j)%NBANK, row (wptr+j)/NBANK.
module fetch_queue_compact
    import frontend_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int NBANK       = 4,
    parameter int PTR_W       = 4,
    localparam int LB    = $clog2(NBANK),
    localparam int ROW_W = PTR_W - LB,
    localparam int NUM_W = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]            i_mask,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] i_data,
    input  logic [PTR_W-1:0]                  i_wptr,
    output logic [FETCH_WIDTH*DATA_WIDTH-1:0] o_packed,
    output logic [NUM_W-1:0]                  o_num,
    output logic [NBANK-1:0]                  o_bank_we,
    output logic [NBANK*ROW_W-1:0]            o_bank_row,
    output logic [NBANK*LB-1:0]               o_bank_lane
);

    assign o_num = NUM_W'(popcount(FQ_MAX_LANES'(i_mask)));

    always_comb begin : compact
        int unsigned slot;
        o_packed = '0;
        slot     = 0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (i_mask[i]) begin
                o_packed[slot*DATA_WIDTH +: DATA_WIDTH] = i_data[i*DATA_WIDTH +: DATA_WIDTH];
                slot++;
            end
        end
    end

    // Each bank receives at most one packed slot because NBANK >= FETCH_WIDTH.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [LB-1:0]    w_offs;
        logic [PTR_W-1:0] w_pos;
        assign w_offs                       = LB'(b) - i_wptr[LB-1:0];
        assign w_pos                        = i_wptr + PTR_W'(w_offs);
        assign o_bank_we[b]                 = 32'(w_offs) < 32'(o_num);
        assign o_bank_row[b*ROW_W +: ROW_W] = w_pos[PTR_W-1:LB];
        assign o_bank_lane[b*LB +: LB]      = w_offs;
    end

endmodule

// File: rtl/fetch_queue.sv
// Banked, compacting instruction queue between fetch and issue.
// Optional same-cycle bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import frontend_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 write_valid_i,
    output logic                                 write_ready_o,
    input  logic [FETCH_WIDTH-1:0]               write_mask_i,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0]    write_data_i,
    output logic [ISSUE_WIDTH-1:0]               read_valid_o,
    input  logic                                 read_ready_i,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     read_num_i,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]    read_data_o,
    output logic [$clog2(DEPTH+1)-1:0]           count_o
);

    localparam int NBANK  = pow2_ceil(max2(FETCH_WIDTH, ISSUE_WIDTH));
    localparam int BANK_D = DEPTH / NBANK;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LB     = $clog2(NBANK);
    localparam int ROW_W  = PTR_W - LB;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int NUM_W  = $clog2(FETCH_WIDTH + 1);

    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_bank [NBANK][BANK_D];

    logic [FETCH_WIDTH*DATA_WIDTH-1:0] w_packed;
    logic [NUM_W-1:0]                  w_num;
    logic [NBANK-1:0]                  w_bank_we;
    logic [NBANK*ROW_W-1:0]            w_bank_row;
    logic [NBANK*LB-1:0]               w_bank_lane;
    logic                              w_push;
    logic [CNT_W-1:0]                  w_push_n;
    logic [CNT_W-1:0]                  w_avail;
    logic [CNT_W-1:0]                  w_req;
    logic [CNT_W-1:0]                  w_pop_n;

    fetch_queue_compact #(
        .DATA_WIDTH (DATA_WIDTH),
        .FETCH_WIDTH(FETCH_WIDTH),
        .NBANK      (NBANK),
        .PTR_W      (PTR_W)
    ) u_compact (
        .i_mask     (write_mask_i),
        .i_data     (write_data_i),
        .i_wptr     (r_wptr),
        .o_packed   (w_packed),
        .o_num      (w_num),
        .o_bank_we  (w_bank_we),
        .o_bank_row (w_bank_row),
        .o_bank_lane(w_bank_lane)
    );

    // Registered count only: issue-side inputs never reach write_ready_o.
    assign write_ready_o = (DEPTH - int'(r_count)) >= FETCH_WIDTH;
    assign w_push        = write_valid_i && write_ready_o && !flush_i;
    assign w_push_n      = w_push ? CNT_W'(w_num) : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic w_byp;
    assign w_byp   = (r_count == '0) && write_valid_i && !flush_i;
    assign w_avail = w_byp ? CNT_W'(w_num) : r_count;
`else
    assign w_avail = r_count;
`endif

    assign w_req   = CNT_W'(read_num_i);
    assign w_pop_n = (read_ready_i && !flush_i) ? ((w_req > w_avail) ? w_avail : w_req) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_push_n);
            r_rptr  <= r_rptr + PTR_W'(w_pop_n);
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NBANK; b++) begin
            if (w_push && w_bank_we[b]) begin
                r_bank[b][w_bank_row[b*ROW_W +: ROW_W]] <=
                    w_packed[int'(w_bank_lane[b*LB +: LB])*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lane i reads entry rptr+i: low pointer bits pick the bank, high bits the row.
    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
        logic [PTR_W-1:0]      w_idx;
        logic [DATA_WIDTH-1:0] w_stored;
        logic                  w_stored_vld;
        assign w_idx        = r_rptr + PTR_W'(i);
        assign w_stored     = r_bank[w_idx[LB-1:0]][w_idx[PTR_W-1:LB]];
        assign w_stored_vld = r_count > CNT_W'(i);
`ifdef FETCH_QUEUE_BYPASS_EN
        if (i < FETCH_WIDTH) begin : g_byp
            assign read_data_o[i*DATA_WIDTH +: DATA_WIDTH] =
                w_byp ? w_packed[i*DATA_WIDTH +: DATA_WIDTH] : w_stored;
            assign read_valid_o[i] = w_byp ? (32'(w_num) > i) : w_stored_vld;
        end else begin : g_nobyp
            assign read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = w_stored;
            assign read_valid_o[i] = !w_byp && w_stored_vld;
        end
`else
        assign read_data_o[i*DATA_WIDTH +: DATA_WIDTH] = w_stored;
        assign read_valid_o[i]                         = w_stored_vld;
`endif
    end

    assign count_o = r_count;

    always @(posedge clk) begin
        if (!rst && read_ready_i && !flush_i) begin
            assert (w_req <= w_avail) else $warning("%s", FQ_MSG_OVERPOP);
        end
    end

endmodule
